// File: rtl/rps_input_conditioner.sv
// rps_input_conditioner: merges board/PMOD buttons, synchronises and debounces them into one choice event per press.
// Optional press counter enabled by defining RPS_PRESS_COUNT_EN.
`default_nettype none

module rps_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic       P1A1,
  input  logic       P1A2,
  input  logic       P1A3,
  output logic [1:0] choice,
  output logic       choice_valid,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cand;
  logic [1:0]       r_choice;
  logic             r_valid;
  logic             r_pressed;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;

  logic [2:0]       w_raw;
  logic             w_any;
  logic             w_cand_in;
  logic             w_accept;

  // Bit 0 rock, bit 1 paper, bit 2 scissors; PMOD lines are active-low.
  assign w_raw = {BTN3 | ~P1A3, BTN2 | ~P1A2, BTN1 | ~P1A1};
  assign w_any = |r_sync2;

  always_comb begin
    w_cand_in = 1'b0;
    case (r_cand)
      2'd1:    w_cand_in = r_sync2[0];
      2'd2:    w_cand_in = r_sync2[1];
      2'd3:    w_cand_in = r_sync2[2];
      default: w_cand_in = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_DEB_PRESS) && w_cand_in && (r_cnt == C_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cand    <= 2'd0;
      r_choice  <= 2'd0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            if (r_sync2[0])      r_cand <= 2'd1;
            else if (r_sync2[1]) r_cand <= 2'd2;
            else                 r_cand <= 2'd3;
            r_cnt   <= '0;
            r_state <= S_DEB_PRESS;
          end
        end
        S_DEB_PRESS: begin
          if (!w_cand_in) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_state   <= S_HELD;
            r_choice  <= r_cand;
            r_valid   <= 1'b1;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!w_any) begin
            r_cnt   <= '0;
            r_state <= S_DEB_RELEASE;
          end
        end
        S_DEB_RELEASE: begin
          // Any re-press, even of a different button, just resumes the held choice.
          if (w_any) begin
            r_state <= S_HELD;
          end else if (r_cnt == C_LAST) begin
            r_state   <= S_IDLE;
            r_choice  <= 2'd0;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RPS_PRESS_COUNT_EN
  logic [7:0] r_press_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_press_count <= 8'd0;
    else if (w_accept) r_press_count <= r_press_count + 8'd1;
  end

  assign press_count = r_press_count;
`else
  assign press_count = 8'd0;
`endif

  assign choice       = r_choice;
  assign choice_valid = r_valid;
  assign pressed      = r_pressed;

endmodule

`default_nettype wire

// File: tb/tb_rps_input_conditioner.sv
// Scoreboard bench for rps_input_conditioner with DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_rps_input_conditioner;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct {
    logic [1:0] ch;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [2:0] pa  = 3'b111;
  logic [1:0] choice;
  logic       choice_valid;
  logic       pressed;
  logic [7:0] press_count;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] exp_cnt = 8'd0;
  logic       prev_valid = 1'b0;

  rps_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .CLK(clk), .RST(rst),
    .BTN1(btn[0]), .BTN2(btn[1]), .BTN3(btn[2]),
    .P1A1(pa[0]), .P1A2(pa[1]), .P1A3(pa[2]),
    .choice(choice), .choice_valid(choice_valid),
    .pressed(pressed), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pops one expectation per pulse; checks choice, arrival cycle and press counter.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] want_cnt;
    if (!rst && choice_valid) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_double cyc=%0d choice_valid high two cycles", cyc);
      end
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse cyc=%0d choice=%0d required no pulse", cyc, choice);
      end else begin
        e = sb.pop_front();
        checks++;
        if (choice !== e.ch || cyc != e.due) begin
          errors++;
          $display("FAIL pulse choice=%0d cyc=%0d required choice=%0d cyc=%0d", choice, cyc, e.ch, e.due);
        end
      end
      exp_cnt = exp_cnt + 8'd1;
`ifdef RPS_PRESS_COUNT_EN
      want_cnt = exp_cnt;
`else
      want_cnt = 8'd0;
`endif
      checks++;
      if (press_count !== want_cnt) begin
        errors++;
        $display("FAIL press_count got=%0d required=%0d", press_count, want_cnt);
      end
    end
    prev_valid = choice_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [1:0] ch);
    exp_t e;
    e.ch  = ch;
    e.due = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      step(1);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_levels(input string name, input logic [1:0] ch, input logic pr);
    checks++;
    if (choice !== ch || pressed !== pr) begin
      errors++;
      $display("FAIL %s choice=%0d pressed=%0b required choice=%0d pressed=%0b", name, choice, pressed, ch, pr);
    end
  endtask

  task automatic release_all();
    btn = 3'b000;
    pa  = 3'b111;
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (choice !== 2'd0 || choice_valid !== 1'b0 || pressed !== 1'b0 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state choice=%0d valid=%0b pressed=%0b count=%0d required all 0",
               choice, choice_valid, pressed, press_count);
    end
    rst = 1'b0;
    exp_cnt = 8'd0;
    step(2);
  endtask

  task automatic test_clean_press();
    int c;
    btn[1] = 1'b1;
    expect_pulse(2'd2);
    step(LAT - 1);
    check_levels("press_before_latency", 2'd0, 1'b0);
    wait_drain("clean_press");
    step(3);
    check_levels("press_held", 2'd2, 1'b1);
    btn[1] = 1'b0;
    c = cyc;
    step(LAT - 1);
    check_levels("release_before_latency", 2'd2, 1'b1);
    step(1);
    check_levels("release_done", 2'd0, 1'b0);
    if (cyc != c + LAT) $display("note: release step misaligned");
    step(3);
  endtask

  task automatic test_pmod();
    pa[2] = 1'b0;
    expect_pulse(2'd3);
    wait_drain("pmod_scissors");
    step(3);
    check_levels("pmod_scissors_held", 2'd3, 1'b1);
    release_all();
    step(LAT + 3);
    check_levels("pmod_scissors_rel", 2'd0, 1'b0);
    btn[0] = 1'b1;
    pa[0]  = 1'b0;
    expect_pulse(2'd1);
    wait_drain("merged_rock");
    step(3);
    check_levels("merged_rock_held", 2'd1, 1'b1);
    release_all();
    step(LAT + 3);
  endtask

  task automatic test_bounce();
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(2);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1;
    expect_pulse(2'd1);
    wait_drain("bounce_press");
    step(3);
    btn[0] = 1'b0; step(1);
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0; step(2);
    btn[0] = 1'b1; step(1);
    btn[0] = 1'b0;
    step(3);
    check_levels("bounce_release_mid", 2'd1, 1'b1);
    step(LAT + 3);
    check_levels("bounce_release_done", 2'd0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_priority_hold();
    btn = 3'b101;
    expect_pulse(2'd1);
    wait_drain("priority");
    step(3);
    btn[0] = 1'b0; step(2);
    btn[1] = 1'b1; step(2);
    btn[2] = 1'b0; step(2);
    check_levels("hold_switch", 2'd1, 1'b1);
    btn[1] = 1'b0;
    step(LAT - 1);
    check_levels("hold_switch_before_rel", 2'd1, 1'b1);
    step(1);
    check_levels("hold_switch_rel", 2'd0, 1'b0);
    step(3);
  endtask

  task automatic async_reset_pulse(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (choice !== 2'd0 || choice_valid !== 1'b0 || pressed !== 1'b0 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL %s choice=%0d valid=%0b pressed=%0b count=%0d required all 0",
               name, choice, choice_valid, pressed, press_count);
    end
    sb.delete();
    exp_cnt = 8'd0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    btn[2] = 1'b1;
    expect_pulse(2'd3);
    step(4);
    async_reset_pulse("reset_in_deb_press");
    expect_pulse(2'd3);
    wait_drain("after_reset_press");
    step(3);
    check_levels("pre_reset_held", 2'd3, 1'b1);
    async_reset_pulse("reset_in_held");
    expect_pulse(2'd3);
    wait_drain("after_reset_held");
    release_all();
    step(LAT + 3);
    check_levels("async_reset_rel", 2'd0, 1'b0);
  endtask

  task automatic test_press_count();
    logic [7:0] want;
    async_reset_pulse("reset_before_count");
    step(2);
    for (int i = 0; i < 257; i++) begin
      btn[i % 3] = 1'b1;
      expect_pulse(2'((i % 3) + 1));
      step(LAT + 2);
      release_all();
      step(LAT + 2);
    end
    wait_drain("count_run");
`ifdef RPS_PRESS_COUNT_EN
    want = 8'd1;
`else
    want = 8'd0;
`endif
    checks++;
    if (press_count !== want) begin
      errors++;
      $display("FAIL press_count_wrap got=%0d required=%0d", press_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_pmod();
    test_bounce();
    test_priority_hold();
    test_async_reset();
    test_press_count();
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rps_input_conditioner.md
Name: rps_input_conditioner

Overview:
- Upstream stage of the rock-paper-scissors game core.
- Takes the three board buttons (active-high) and the three PMOD inputs (active-low) and synchronises each pair into one asserted level per choice.
- Debounces the press and release of the selected button.
- Delivers one clean, one-cycle choice event per physical press, plus a held choice code, so the game core never sees bounce or multiple choices.

Parameters:
- DEBOUNCE_CYCLES, 120000, number of consecutive stable cycles needed to accept a press or a release (10 ms at 12 MHz); legal range is 1 to 2^CNT_W-1.
- CNT_W, 17, width of the debounce counter.

Ports:
- CLK  input  1  system clock (12 MHz)
- RST  input  1  asynchronous reset, active-high
- BTN1  input  1  rock button, active-high
- BTN2  input  1  paper button, active-high
- BTN3  input  1  scissors button, active-high
- P1A1  input  1  rock PMOD input, active-low
- P1A2  input  1  paper PMOD input, active-low
- P1A3  input  1  scissors PMOD input, active-low
- choice  output  2  accepted choice: 0 none, 1 ROCK, 2 PAPER, 3 SCISSORS
- choice_valid  output  1  one-cycle pulse when a new choice is accepted
- pressed  output  1  high while an accepted choice is held (in HELD or DEB_RELEASE)
- press_count  output  8  number of accepted presses (see Optional Feature)

Behaviour:
- Input forming: raw_rock = BTN1 | ~P1A1, and likewise for paper and scissors.
  - Each raw_x passes through a 2-flop synchroniser; the FSM uses only synced values.
  - Synchroniser flops reset to 0 (released).
- Reset (asynchronous): state IDLE, counter 0, candidate 0, choice 0, choice_valid 0, pressed 0, press_count 0.
  - Reset asserted mid-operation aborts immediately; no pulse is emitted.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- IDLE:
  - If any synced input is high: latch candidate by priority ROCK > PAPER > SCISSORS, clear the counter, go to DEB_PRESS.
- DEB_PRESS:
  - Only the candidate's synced input is examined; the other inputs are ignored.
  - Candidate low: go to IDLE and emit no pulse.
  - Candidate high with counter < DEBOUNCE_CYCLES-1: increment the counter.
  - Candidate high with counter == DEBOUNCE_CYCLES-1: go to HELD, load choice with candidate, assert choice_valid for one cycle, set pressed.
- HELD:
  - choice and pressed hold.
  - When all three synced inputs are low: clear the counter, go to DEB_RELEASE.
- DEB_RELEASE:
  - Any synced input high: return to HELD with no new pulse and choice unchanged. Releasing one button while pressing another therefore never yields a second choice.
  - All inputs low with counter == DEBOUNCE_CYCLES-1: go to IDLE, clear choice to 0, deassert pressed. Otherwise increment the counter.
- Latency: choice_valid is high in the cycle after rising edge DEBOUNCE_CYCLES+3, counting from the first edge that samples a stable asserted raw input. Breakdown:
  - 2 edges through the synchroniser;
  - 1 edge for IDLE to DEB_PRESS;
  - DEBOUNCE_CYCLES edges of counting.
- Release latency: choice returns to 0 DEBOUNCE_CYCLES+3 edges after the last input goes stable-released.
- choice_valid is registered and is never high for two consecutive cycles.
- The counter never exceeds DEBOUNCE_CYCLES-1 and has no wrap path.
- Simultaneous presses landing on the same edge resolve by priority (ROCK > PAPER > SCISSORS).

Optional Feature:
- Macro: RPS_PRESS_COUNT_EN.
- Defined: press_count is an 8-bit register that increments on every choice_valid pulse, wraps from 255 to 0, and is cleared by RST.
- Undefined: press_count is tied to constant 0 and no counter logic is synthesised. The port list is identical either way.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold BTN2=1 cleanly → choice_valid pulses exactly once, 7 edges after the first sampling edge; choice=2; pressed=1. Release → choice=0 and pressed=0 seven edges later.
- Pull P1A3 low (BTN3=0) → choice=3 with one pulse. Drive BTN1=1 and P1A1=0 together → choice=1 with one pulse, since the OR merge does not double-count.
- Bounce on BTN1: pulses of 1,2,1 cycles separated by 1-cycle gaps, then stable high → no pulse during the bounce, exactly one pulse with choice=1 after the stable period. Bounce on release → still exactly one pulse in total.
- Assert BTN1 and BTN3 on the same edge → choice=1. Then, while held: release BTN1, press BTN2, release BTN3 → no further choice_valid and choice stays 1 until everything is released for 4+ cycles.
- Assert RST asynchronously (between clock edges) during DEB_PRESS and during HELD → all outputs are 0 immediately. After deassert with the button still held → a fresh full-latency pulse.
- With RPS_PRESS_COUNT_EN: perform 257 clean presses → press_count=1 (wrapped). Without the macro → press_count stays 0 throughout.
